mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
Pipeline memory stage, directly downstream of the execute stage and upstream of the writeback stage.
- Accepts the execute-to-memory bus and tracks the single outstanding data-SRAM transaction issued when the execute stage hands over a load or store.
- Waits for data_ok, then aligns and extends load data and forwards the result.
- Drives hazard/forward information to decode and the exception/eret kill indication back to execute.

Parameters:
ES_TO_MS_BUS_WD, 105, execute-to-memory bus width
MS_TO_WS_BUS_WD, 94, memory-to-writeback bus width
STALL_BUS_WD, 10, stall bus width
FORWARD_BUS_WD, 33, forward bus width

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
flush  in  1  exception/eret pipeline flush
ws_allowin  in  1  writeback can accept
ms_allowin  out  1  this stage can accept
es_to_ms_valid  in  1  execute output valid
es_to_ms_bus  in  ES_TO_MS_BUS_WD  {store_op[104], bd[103], exc[102], exc_type[101:94], eret[93], cp0_wen[92], res_from_cp0[91], cp0_addr[90:83], res_from_mem[82], inst_load[81:75], ld_extd_op[74:70], gr_we[69], dest[68:64], alu_result[63:32], pc[31:0]}
ms_to_ws_valid  out  1  output valid
ms_to_ws_bus  out  MS_TO_WS_BUS_WD  {bd, exc, exc_type[7:0], eret, cp0_wen, res_from_cp0, cp0_addr[7:0], rf_wstrb[3:0], dest[4:0], result[31:0], pc[31:0]}
stall_ms_bus  out  STALL_BUS_WD  {{5{ms_valid&gr_we}}, dest}
forward_ms_bus  out  FORWARD_BUS_WD  {fwd_valid, result}
ms_exc_eret  out  1  ms_valid & (exc | eret), kills execute-stage side effects
data_sram_data_ok  in  1  response for oldest request
data_sram_rdata  in  32  response data

Behaviour:
- Reset (async): ms_valid=0, state=EMPTY, discard=0, data buffer=0. Outputs: ms_to_ws_valid=0, ms_allowin=1, ms_exc_eret=0, fwd_valid=0.
- Bus register loads on es_to_ms_valid & ms_allowin.
- mem_op = res_from_mem | store_op. A request was issued for every accepted mem_op, even when exc=1, so a response is always awaited.
- States:
  - EMPTY: on accept, go to WAIT if mem_op, else READY.
  - WAIT: on data_ok, latch rdata and go to READY.
  - READY: on ws_allowin, go to next accept target or EMPTY.
- Handshake:
  - ready_go = (state != WAIT).
  - ms_to_ws_valid = ms_valid & ready_go.
  - ms_allowin = !discard & (!ms_valid | ready_go & ws_allowin).
  - WAIT + data_ok + ws_allowin in the same cycle: the response is not forwarded that cycle (1-cycle minimum latency from data_ok to ms_to_ws_valid).
- Flush: ms_valid<=0 next edge and the bus register load is blocked.
  - If state=WAIT and no data_ok that cycle, set discard=1.
  - The next data_ok clears discard and is dropped.
  - A flush coinciding with data_ok in WAIT leaves discard=0.
  - ms_allowin=0 while discard=1, so at most one request is ever outstanding.
- Load data uses inst_load one-hot: [0]lw [1]lb [2]lbu [3]lh [4]lhu [5]lwl [6]lwr, with a=alu_result[1:0]. ld_extd_op is ignored.
  - lb/lbu: byte a, sign/zero extended. lh/lhu: halfword a[1].
  - lw: as is.
  - lwl: rdata<<(8*(3-a)), rf_wstrb = 4'b1111<<(3-a).
  - lwr: rdata>>(8*a), rf_wstrb = 4'b1111>>a.
  - rf_wstrb=4'b1111 for every other writing instruction.
  - rf_wstrb=0 when gr_we=0, exc=1, or store.
- result = aligned load data if res_from_mem, else alu_result (cp0 read data inserted in writeback).
- fwd_valid = ms_valid & !res_from_cp0 & ready_go & !(lwl|lwr).
- data_ok while EMPTY/READY with discard=0 is a protocol violation; it is ignored and must be flagged by a bench assertion.
- Reset mid-WAIT: state cleared; the external bus is reset alongside.

Test Plan:
1. ALU add, alu_result=0x1234, ws_allowin=1 -> ms_to_ws_valid the cycle after accept, result=0x1234, rf_wstrb=4'hF, fwd_valid=1.
2. lb at addr ...02, data_ok 3 cycles later with rdata=0x00800000 -> ready_go low 3 cycles, then result=0xFFFFFF80; lbu same -> 0x00000080.
3. lwl at a=1, rdata=0xAABBCCDD -> result=0xCCDD0000, rf_wstrb=4'b1100; lwr at a=1 -> 0x00AABBCC, rf_wstrb=4'b0111.
4. Flush during WAIT, data_ok 2 cycles later, next load accepted afterwards -> ms_allowin=0 until stale data_ok, which is dropped; new load returns its own data.
5. Flush and data_ok in the same cycle -> discard stays 0; next accept is allowed the following cycle.
6. Store with exc=1 (AdES) -> ms_exc_eret=1, waits for data_ok, forwards with exc=1 and rf_wstrb=0; ws_allowin=0 holds output stable.

Source files
------------

// File: rtl/mem_stage.sv
// Pipeline memory stage: holds one execute-stage instruction, waits for its single
// outstanding data-SRAM response, aligns/extends load data and hands off to writeback.
module mem_stage #(
  parameter int ES_TO_MS_BUS_WD = 105,
  parameter int MS_TO_WS_BUS_WD = 94,
  parameter int STALL_BUS_WD    = 10,
  parameter int FORWARD_BUS_WD  = 33
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [STALL_BUS_WD-1:0]    stall_ms_bus,
  output logic [FORWARD_BUS_WD-1:0]  forward_ms_bus,
  output logic                       ms_exc_eret,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  localparam int STORE_OP_BIT     = 104;
  localparam int RES_FROM_MEM_BIT = 82;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_e;

  typedef struct packed {
    logic        store_op;
    logic        bd;
    logic        exc;
    logic [7:0]  exc_type;
    logic        eret;
    logic        cp0_wen;
    logic        res_from_cp0;
    logic [7:0]  cp0_addr;
    logic        res_from_mem;
    logic [6:0]  inst_load;
    logic [4:0]  ld_extd_op;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_bus_t;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] rdata_q, rdata_d;
  es_bus_t     es_bus_q;

  logic ms_valid;
  logic ready_go;
  logic accept;
  logic in_mem_op;

  assign ms_valid  = (state_q != S_EMPTY);
  assign ready_go  = (state_q != S_WAIT);
  assign in_mem_op = es_to_ms_bus[STORE_OP_BIT] | es_to_ms_bus[RES_FROM_MEM_BIT];

  assign ms_allowin     = !discard_q && (!ms_valid || (ready_go && ws_allowin));
  assign ms_to_ws_valid = ms_valid && ready_go;
  assign accept         = es_to_ms_valid && ms_allowin && !flush;

  always_comb begin
    // NOTE: every variable gets its default before the case so no latch is inferred.
    state_d   = state_q;
    discard_d = discard_q;
    rdata_d   = rdata_q;

    unique case (state_q)
      S_EMPTY: begin
        if (accept) state_d = in_mem_op ? S_WAIT : S_READY;
      end
      S_WAIT: begin
        // The response only becomes visible from the register, never combinationally.
        if (data_sram_data_ok) begin
          rdata_d = data_sram_rdata;
          state_d = S_READY;
        end
      end
      S_READY: begin
        if (ws_allowin) begin
          if (accept) state_d = in_mem_op ? S_WAIT : S_READY;
          else        state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase

    // A stale response for a flushed request retires the discard and is dropped.
    if (discard_q && data_sram_data_ok) discard_d = 1'b0;

    if (flush) begin
      state_d = S_EMPTY;
      if (state_q == S_WAIT && !data_sram_data_ok) discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the data buffer is reset too; it is a single word, not a memory array.
      state_q   <= S_EMPTY;
      discard_q <= 1'b0;
      rdata_q   <= '0;
      es_bus_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q   <= state_d;
      discard_q <= discard_d;
      rdata_q   <= rdata_d;
      if (accept) es_bus_q <= es_to_ms_bus;
    end
  end

  logic [1:0]  addr_lo;
  logic [31:0] rdata_shr;
  logic [31:0] lwl_data;
  logic [15:0] ld_half;
  logic [31:0] load_data;
  logic [3:0]  rf_wstrb;
  logic [31:0] ms_result;
  logic        is_lwl, is_lwr;

  assign addr_lo   = es_bus_q.alu_result[1:0];
  assign rdata_shr = rdata_q >> {addr_lo, 3'b000};
  assign lwl_data  = rdata_q << {~addr_lo, 3'b000};
  assign ld_half   = addr_lo[1] ? rdata_q[31:16] : rdata_q[15:0];
  assign is_lwl    = es_bus_q.inst_load[5];
  assign is_lwr    = es_bus_q.inst_load[6];

  always_comb begin
    load_data = rdata_q;
    if      (es_bus_q.inst_load[1]) load_data = {{24{rdata_shr[7]}}, rdata_shr[7:0]};
    else if (es_bus_q.inst_load[2]) load_data = {24'b0, rdata_shr[7:0]};
    else if (es_bus_q.inst_load[3]) load_data = {{16{ld_half[15]}}, ld_half};
    else if (es_bus_q.inst_load[4]) load_data = {16'b0, ld_half};
    else if (is_lwl)                load_data = lwl_data;
    else if (is_lwr)                load_data = rdata_shr;
  end

  always_comb begin
    rf_wstrb = 4'b1111;
    if (!es_bus_q.gr_we || es_bus_q.exc || es_bus_q.store_op) rf_wstrb = 4'b0000;
    else if (is_lwl)                                         rf_wstrb = 4'b1111 << ~addr_lo;
    else if (is_lwr)                                         rf_wstrb = 4'b1111 >> addr_lo;
  end

  assign ms_result = es_bus_q.res_from_mem ? load_data : es_bus_q.alu_result;

  assign ms_to_ws_bus = {es_bus_q.bd, es_bus_q.exc, es_bus_q.exc_type, es_bus_q.eret,
                         es_bus_q.cp0_wen, es_bus_q.res_from_cp0, es_bus_q.cp0_addr,
                         rf_wstrb, es_bus_q.dest, ms_result, es_bus_q.pc};

  assign stall_ms_bus   = {{5{ms_valid & es_bus_q.gr_we}}, es_bus_q.dest};
  // Partial-register loads cannot be forwarded; writeback merges them first.
  assign forward_ms_bus = {ms_valid & !es_bus_q.res_from_cp0 & ready_go & !(is_lwl | is_lwr),
                           ms_result};
  assign ms_exc_eret    = ms_valid & (es_bus_q.exc | es_bus_q.eret);

  // Load extension is fully described by inst_load; lw is the default path.
  logic unused_ok;
  assign unused_ok = ^{es_bus_q.ld_extd_op, es_bus_q.inst_load[0]};

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: ALU pass-through, load alignment,
// flush/discard handling, exception store and writeback back-pressure.
module tb_mem_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         flush;
  logic         ws_allowin;
  logic         ms_allowin;
  logic         es_to_ms_valid;
  logic [104:0] es_to_ms_bus;
  logic         ms_to_ws_valid;
  logic [93:0]  ms_to_ws_bus;
  logic [9:0]   stall_ms_bus;
  logic [32:0]  forward_ms_bus;
  logic         ms_exc_eret;
  logic         data_sram_data_ok;
  logic [31:0]  data_sram_rdata;

  int errors = 0;
  int checks = 0;
  bit resp_exp = 1'b0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .flush             (flush),
    .ws_allowin        (ws_allowin),
    .ms_allowin        (ms_allowin),
    .es_to_ms_valid    (es_to_ms_valid),
    .es_to_ms_bus      (es_to_ms_bus),
    .ms_to_ws_valid    (ms_to_ws_valid),
    .ms_to_ws_bus      (ms_to_ws_bus),
    .stall_ms_bus      (stall_ms_bus),
    .forward_ms_bus    (forward_ms_bus),
    .ms_exc_eret       (ms_exc_eret),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  always #5 clk = ~clk;

  wire [31:0] o_result = ms_to_ws_bus[63:32];
  wire [3:0]  o_wstrb  = ms_to_ws_bus[72:69];

  // A response must only arrive while the bench knows a request is outstanding.
  always @(posedge clk) begin
    if (!reset && data_sram_data_ok) begin
      checks++;
      if (!resp_exp) begin
        errors++;
        $display("FAIL proto_data_ok: data_ok=1 required no response outstanding");
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [104:0] mk_bus(input logic st, input logic ex, input logic rfm,
                                          input logic rfc, input logic [6:0] ld,
                                          input logic we, input logic [4:0] dst,
                                          input logic [31:0] alu, input logic [31:0] pc);
    return {st, 1'b0, ex, (ex ? 8'h05 : 8'h00), 1'b0, 1'b0, rfc, 8'h0C, rfm, ld,
            5'b10101, we, dst, alu, pc};
  endfunction

  function automatic logic [93:0] mk_out(input logic ex, input logic rfc, input logic [3:0] ws,
                                         input logic [4:0] dst, input logic [31:0] res,
                                         input logic [31:0] pc);
    return {1'b0, ex, (ex ? 8'h05 : 8'h00), 1'b0, 1'b0, rfc, 8'h0C, ws, dst, res, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; ws_allowin = 1'b1; es_to_ms_valid = 1'b0;
    es_to_ms_bus = '0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    #2;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ms_to_ws_valid); end
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL reset_allowin: got %b want 1", ms_allowin); end
    checks++; if (ms_exc_eret !== 1'b0) begin errors++; $display("FAIL reset_exc_eret: got %b want 0", ms_exc_eret); end
    checks++; if (forward_ms_bus[32] !== 1'b0) begin errors++; $display("FAIL reset_fwd_valid: got %b want 0", forward_ms_bus[32]); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  task automatic do_alu(input string name, input logic [31:0] alu, input logic [4:0] dst);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0, 0, 0, 0, 7'b0, 1, dst, alu, 32'hBFC0_0000);
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL %s_allowin: got %b want 1", name, ms_allowin); end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, ms_to_ws_valid); end
    checks++; if (o_result !== alu) begin errors++; $display("FAIL %s_result: got %h want %h", name, o_result, alu); end
    checks++; if (o_wstrb !== 4'hF) begin errors++; $display("FAIL %s_wstrb: got %h want f", name, o_wstrb); end
    checks++; if (forward_ms_bus !== {1'b1, alu}) begin errors++; $display("FAIL %s_fwd: got %h want %h", name, forward_ms_bus, {1'b1, alu}); end
    checks++; if (stall_ms_bus !== {5'b11111, dst}) begin errors++; $display("FAIL %s_stall: got %h want %h", name, stall_ms_bus, {5'b11111, dst}); end
    tick();
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL %s_retire: got %b want 0", name, ms_to_ws_valid); end
  endtask

  // delay = cycles from the accept edge to the data_ok edge (>=1).
  task automatic do_load(input string name, input logic [104:0] bus, input logic [31:0] rd,
                         input int delay, input logic [31:0] exp_res, input logic [3:0] exp_ws,
                         input logic exp_fwd);
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = bus;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL %s_allowin: got %b want 1", name, ms_allowin); end
    tick();
    es_to_ms_valid = 1'b0;
    for (int i = 1; i <= delay; i++) begin
      if (i == delay) begin resp_exp = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = rd; end
      #1;
      checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL %s_wait%0d: got valid=%b want 0", name, i, ms_to_ws_valid); end
      tick();
    end
    data_sram_data_ok = 1'b0; resp_exp = 1'b0; data_sram_rdata = '0;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL %s_valid: got %b want 1", name, ms_to_ws_valid); end
    checks++; if (o_result !== exp_res) begin errors++; $display("FAIL %s_result: got %h want %h", name, o_result, exp_res); end
    checks++; if (o_wstrb !== exp_ws) begin errors++; $display("FAIL %s_wstrb: got %h want %h", name, o_wstrb, exp_ws); end
    checks++; if (forward_ms_bus !== {exp_fwd, exp_res}) begin errors++; $display("FAIL %s_fwd: got %h want %h", name, forward_ms_bus, {exp_fwd, exp_res}); end
    tick();
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL %s_retire: got %b want 0", name, ms_to_ws_valid); end
  endtask

  task automatic test_alu();
    do_alu("alu_add", 32'h0000_1234, 5'd5);
  endtask

  task automatic test_loads();
    do_load("lb",  mk_bus(0,0,1,0,7'b0000010,1,5'd6,32'h1002,32'h100), 32'h0080_0000, 3, 32'hFFFF_FF80, 4'hF, 1'b1);
    do_load("lbu", mk_bus(0,0,1,0,7'b0000100,1,5'd6,32'h1002,32'h104), 32'h0080_0000, 3, 32'h0000_0080, 4'hF, 1'b1);
    do_load("lb3", mk_bus(0,0,1,0,7'b0000010,1,5'd6,32'h1003,32'h108), 32'h7F00_0000, 1, 32'h0000_007F, 4'hF, 1'b1);
    do_load("lh",  mk_bus(0,0,1,0,7'b0001000,1,5'd7,32'h2002,32'h10C), 32'h8001_1234, 1, 32'hFFFF_8001, 4'hF, 1'b1);
    do_load("lhu", mk_bus(0,0,1,0,7'b0010000,1,5'd7,32'h2002,32'h110), 32'h8001_1234, 2, 32'h0000_8001, 4'hF, 1'b1);
    do_load("lw",  mk_bus(0,0,1,0,7'b0000001,1,5'd8,32'h3000,32'h114), 32'h1122_3344, 1, 32'h1122_3344, 4'hF, 1'b1);
    do_load("lwl", mk_bus(0,0,1,0,7'b0100000,1,5'd9,32'h3001,32'h118), 32'hAABB_CCDD, 1, 32'hCCDD_0000, 4'hC, 1'b0);
    do_load("lwr", mk_bus(0,0,1,0,7'b1000000,1,5'd9,32'h3001,32'h11C), 32'hAABB_CCDD, 1, 32'h00AA_BBCC, 4'h7, 1'b0);
  endtask

  task automatic test_back_to_back();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0,0,0,0,7'b0,1,5'd1,32'hA,32'h200);
    tick();
    es_to_ms_bus   = mk_bus(0,0,0,0,7'b0,1,5'd2,32'hB,32'h204);
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_first_valid: got %b want 1", ms_to_ws_valid); end
    checks++; if (o_result !== 32'hA) begin errors++; $display("FAIL b2b_first_result: got %h want a", o_result); end
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL b2b_allowin: got %b want 1", ms_allowin); end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_valid: got %b want 1", ms_to_ws_valid); end
    checks++; if (o_result !== 32'hB) begin errors++; $display("FAIL b2b_second_result: got %h want b", o_result); end
    tick();
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL b2b_retire: got %b want 0", ms_to_ws_valid); end
  endtask

  task automatic test_flush_wait();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0,0,1,0,7'b0000001,1,5'd3,32'h2000,32'h300);
    tick();
    es_to_ms_valid = 1'b0;
    flush = 1'b1;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fw_flush_valid: got %b want 0", ms_to_ws_valid); end
    tick();
    flush = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0,0,1,0,7'b0000001,1,5'd4,32'h3000,32'h304);
    #1;
    checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL fw_discard_allowin1: got %b want 0", ms_allowin); end
    tick();
    resp_exp = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'hDEAD_BEEF;
    #1;
    checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL fw_discard_allowin2: got %b want 0", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fw_stale_valid: got %b want 0", ms_to_ws_valid); end
    tick();
    resp_exp = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL fw_after_stale_allowin: got %b want 1", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fw_stale_dropped: got %b want 0", ms_to_ws_valid); end
    do_load("fw_new", mk_bus(0,0,1,0,7'b0000001,1,5'd4,32'h3000,32'h304), 32'h5566_7788, 2, 32'h5566_7788, 4'hF, 1'b1);
  endtask

  task automatic test_flush_dok();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0,0,1,0,7'b0000001,1,5'd3,32'h2000,32'h400);
    tick();
    es_to_ms_valid = 1'b0;
    flush = 1'b1; resp_exp = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h5555_5555;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_valid: got %b want 0", ms_to_ws_valid); end
    tick();
    flush = 1'b0; resp_exp = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL fd_allowin: got %b want 1", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL fd_empty: got %b want 0", ms_to_ws_valid); end
    do_alu("fd_next", 32'h0000_0077, 5'd7);
  endtask

  task automatic test_store_exc();
    logic [93:0] exp_out;
    exp_out = mk_out(1'b1, 1'b0, 4'h0, 5'd0, 32'h0000_1001, 32'hBFC0_0100);
    ws_allowin     = 1'b0;
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(1,1,0,0,7'b0,0,5'd0,32'h1001,32'hBFC0_0100);
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL st_allowin: got %b want 1", ms_allowin); end
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++; if (ms_exc_eret !== 1'b1) begin errors++; $display("FAIL st_exc_eret: got %b want 1", ms_exc_eret); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL st_wait_valid: got %b want 0", ms_to_ws_valid); end
    tick();
    resp_exp = 1'b1; data_sram_data_ok = 1'b1; data_sram_rdata = 32'h0;
    tick();
    resp_exp = 1'b0; data_sram_data_ok = 1'b0;
    #1;
    checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL st_valid: got %b want 1", ms_to_ws_valid); end
    checks++; if (ms_to_ws_bus !== exp_out) begin errors++; $display("FAIL st_bus: got %h want %h", ms_to_ws_bus, exp_out); end
    checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL st_blocked_allowin: got %b want 0", ms_allowin); end
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++; if (ms_to_ws_valid !== 1'b1) begin errors++; $display("FAIL st_hold_valid%0d: got %b want 1", k, ms_to_ws_valid); end
      checks++; if (ms_to_ws_bus !== exp_out) begin errors++; $display("FAIL st_hold_bus%0d: got %h want %h", k, ms_to_ws_bus, exp_out); end
    end
    ws_allowin = 1'b1;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL st_release_allowin: got %b want 1", ms_allowin); end
    tick();
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL st_retire: got %b want 0", ms_to_ws_valid); end
    checks++; if (ms_exc_eret !== 1'b0) begin errors++; $display("FAIL st_exc_clear: got %b want 0", ms_exc_eret); end
  endtask

  task automatic test_reset_mid_wait();
    es_to_ms_valid = 1'b1;
    es_to_ms_bus   = mk_bus(0,0,1,0,7'b0000001,1,5'd3,32'h2000,32'h500);
    tick();
    es_to_ms_valid = 1'b0;
    #1;
    checks++; if (ms_allowin !== 1'b0) begin errors++; $display("FAIL rw_wait_allowin: got %b want 0", ms_allowin); end
    reset = 1'b1;
    #1;
    checks++; if (ms_allowin !== 1'b1) begin errors++; $display("FAIL rw_reset_allowin: got %b want 1", ms_allowin); end
    checks++; if (ms_to_ws_valid !== 1'b0) begin errors++; $display("FAIL rw_reset_valid: got %b want 0", ms_to_ws_valid); end
    @(negedge clk);
    reset = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_back_to_back();
    test_flush_wait();
    test_flush_dok();
    test_store_exc();
    test_reset_mid_wait();
    do_alu("post_reset", 32'hCAFE_0001, 5'd10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
